// File: rtl/bagua_pkg.sv
// bagua_pkg -- shared definitions for the hexagram builder.
//   * eight trigram encodings (bit0 = bottom line, 1 = yang)
//   * FSM state type
//   * King Wen number table, indexed by the 6-bit {upper, lower} hexagram code
package bagua_pkg;

  localparam logic [2:0] QIAN = 3'b111;
  localparam logic [2:0] KUN  = 3'b000;
  localparam logic [2:0] ZHEN = 3'b001;
  localparam logic [2:0] KAN  = 3'b010;
  localparam logic [2:0] GEN  = 3'b100;
  localparam logic [2:0] XUN  = 3'b110;
  localparam logic [2:0] LI   = 3'b101;
  localparam logic [2:0] DUI  = 3'b011;

  typedef enum logic [1:0] {
    WAIT_LOWER = 2'd0,
    WAIT_UPPER = 2'd1,
    HOLD       = 2'd2
  } bagua_state_e;

  // Entry index = {upper, lower}. Each row is one upper trigram, columns walk
  // the lower trigram in encoding order KUN, ZHEN, KAN, DUI, GEN, LI, XUN, QIAN.
  localparam logic [0:63][6:0] KING_WEN_TBL = {
    7'd2,  7'd24, 7'd7,  7'd19, 7'd15, 7'd36, 7'd46, 7'd11,  // upper KUN
    7'd16, 7'd51, 7'd40, 7'd54, 7'd62, 7'd55, 7'd32, 7'd34,  // upper ZHEN
    7'd8,  7'd3,  7'd29, 7'd60, 7'd39, 7'd63, 7'd48, 7'd5,   // upper KAN
    7'd45, 7'd17, 7'd47, 7'd58, 7'd31, 7'd49, 7'd28, 7'd43,  // upper DUI
    7'd23, 7'd27, 7'd4,  7'd41, 7'd52, 7'd22, 7'd18, 7'd26,  // upper GEN
    7'd35, 7'd21, 7'd64, 7'd38, 7'd56, 7'd30, 7'd50, 7'd14,  // upper LI
    7'd20, 7'd42, 7'd59, 7'd61, 7'd53, 7'd37, 7'd57, 7'd9,   // upper XUN
    7'd12, 7'd25, 7'd6,  7'd10, 7'd33, 7'd13, 7'd44, 7'd1    // upper QIAN
  };

endpackage

// File: rtl/bagua_kingwen_lut.sv
// bagua_kingwen_lut -- combinational King Wen number lookup.
// Ports:
//   code_i     [5:0]  hexagram code {upper, lower}, bit0 = bottom line
//   king_wen_o [6:0]  King Wen number 1..64
module bagua_kingwen_lut
  import bagua_pkg::*;
(
  input  logic [5:0] code_i,
  output logic [6:0] king_wen_o
);

  assign king_wen_o = KING_WEN_TBL[code_i];

endmodule

// File: rtl/bagua_hexagram_builder.sv
// bagua_hexagram_builder -- pairs incoming trigrams (lower first, then upper)
// into hexagrams and offers them on a valid/ready output register.
// Build option: define BAGUA_KINGWEN_EN to register the King Wen number next
// to hex_code; otherwise king_wen is tied to 0 and no table is built.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   en                global enable; low freezes all state (reset still works)
//   tri_in, tri_valid trigram input and its one-cycle strobe
//   hex_code          {upper, lower} of the offered hexagram
//   king_wen          King Wen number of hex_code (0 when option disabled)
//   hex_valid/ready   output handshake
//   hex_count         hexagrams accepted downstream, wraps
//   overflow          sticky: a hexagram completed while the output was stalled
module bagua_hexagram_builder
  import bagua_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       tri_in,
  input  logic             tri_valid,
  output logic [5:0]       hex_code,
  output logic [6:0]       king_wen,
  output logic             hex_valid,
  input  logic             hex_ready,
  output logic [CNT_W-1:0] hex_count,
  output logic             overflow
);

  bagua_state_e     state_q, state_d;
  logic [2:0]       lower_q, lower_d;
  logic [2:0]       sh_lower_q, sh_lower_d;
  logic             sh_has_lower_q, sh_has_lower_d;
  logic [5:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             load_s;
  logic             strobe_s;
  logic             accept_s;

  // en gates the handshake too, so nothing advances while disabled
  assign strobe_s = tri_valid && en;
  assign accept_s = valid_q && hex_ready && en;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= WAIT_LOWER;
      lower_q        <= 3'b000;
      sh_lower_q     <= 3'b000;
      sh_has_lower_q <= 1'b0;
      code_q         <= 6'b000000;
      valid_q        <= 1'b0;
      cnt_q          <= {CNT_W{1'b0}};
      ovf_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      lower_q        <= lower_d;
      sh_lower_q     <= sh_lower_d;
      sh_has_lower_q <= sh_has_lower_d;
      code_q         <= code_d;
      valid_q        <= valid_d;
      cnt_q          <= cnt_d;
      ovf_q          <= ovf_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d        = state_q;
    lower_d        = lower_q;
    sh_lower_d     = sh_lower_q;
    sh_has_lower_d = sh_has_lower_q;
    code_d         = code_q;
    valid_d        = valid_q;
    cnt_d          = cnt_q;
    ovf_d          = ovf_q;
    load_s         = 1'b0;
    case (state_q)
      WAIT_LOWER: begin
        if (strobe_s) begin
          lower_d = tri_in;
          state_d = WAIT_UPPER;
        end else begin
          state_d = WAIT_LOWER;
        end
      end
      WAIT_UPPER: begin
        if (strobe_s) begin
          code_d  = {tri_in, lower_q};
          valid_d = 1'b1;
          load_s  = 1'b1;
          state_d = HOLD;
        end else begin
          state_d = WAIT_UPPER;
        end
      end
      HOLD: begin
        if (accept_s) begin
          valid_d        = 1'b0;
          cnt_d          = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          sh_lower_d     = 3'b000;
          sh_has_lower_d = 1'b0;
          // A strobe coinciding with acceptance starts the next pair
          if (strobe_s) begin
            lower_d = tri_in;
            state_d = WAIT_UPPER;
          end else begin
            state_d = WAIT_LOWER;
          end
        end else if (strobe_s) begin
          // Output still stalled: keep pairing in the shadow slot; a
          // completed shadow pair has nowhere to go and is dropped.
          if (!sh_has_lower_q) begin
            sh_lower_d     = tri_in;
            sh_has_lower_d = 1'b1;
          end else begin
            sh_lower_d     = 3'b000;
            sh_has_lower_d = 1'b0;
            ovf_d          = 1'b1;
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = WAIT_LOWER;
      end
    endcase
  end

`ifdef BAGUA_KINGWEN_EN
  logic [6:0] kw_lut_s;
  logic [6:0] kw_q, kw_d;

  bagua_kingwen_lut u_kingwen_lut (
    .code_i     ({tri_in, lower_q}),
    .king_wen_o (kw_lut_s)
  );

  // King Wen number follows hex_code only when a new hexagram is loaded
  always_comb begin
    kw_d = kw_q;
    if (load_s) begin
      kw_d = kw_lut_s;
    end else begin
      kw_d = kw_q;
    end
  end

  // King Wen output register
  always_ff @(posedge clk) begin
    if (rst) begin
      kw_q <= 7'd0;
    end else begin
      kw_q <= kw_d;
    end
  end

  assign king_wen = kw_q;
`else
  logic unused_load_s;
  assign unused_load_s = load_s;
  assign king_wen      = 7'd0;
`endif

  assign hex_code  = code_q;
  assign hex_valid = valid_q;
  assign hex_count = cnt_q;
  assign overflow  = ovf_q;

endmodule
